// File: rtl/rcdp_level_scaler.sv
// Turns raw RC-discharge counts into a calibrated 0..15 pot level: moving average,
// running min/max auto-calibration, then a bit-serial restoring divide.
module rcdp_level_scaler #(
   parameter int AVG_LOG2 = 2,
   parameter int SAMPLE_W = 32
) (
   input  logic                clki,
   input  logic                resetn,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                cal_clear,
   output logic [3:0]          level,
   output logic                level_valid,
   output logic [SAMPLE_W-1:0] avg,
   output logic [SAMPLE_W-1:0] cal_min,
   output logic [SAMPLE_W-1:0] cal_max,
   output logic                busy,
   output logic                overrun
);

   localparam int WIN   = 1 << AVG_LOG2;
   localparam int SUM_W = SAMPLE_W + AVG_LOG2;
   localparam int NUM_W = SAMPLE_W + 4;
   localparam int DEN_W = SAMPLE_W + 1;
   localparam int CNT_W = $clog2(NUM_W);
   localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(WIN);

   typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_CAL, S_DIVIDE, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [SAMPLE_W-1:0]  smp_q, smp_d;
   logic [SAMPLE_W-1:0]  win_q [WIN];
   logic [SAMPLE_W-1:0]  win_d [WIN];
   logic [AVG_LOG2-1:0]  ptr_q, ptr_d;
   logic [AVG_LOG2:0]    fill_q, fill_d;
   logic [SUM_W-1:0]     sum_q, sum_d;
   logic [SAMPLE_W-1:0]  avg_q, avg_d;
   logic [SAMPLE_W-1:0]  min_q, min_d;
   logic [SAMPLE_W-1:0]  max_q, max_d;
   logic [3:0]           level_q, level_d;
   logic                 lv_q, lv_d;
   logic                 ovr_q, ovr_d;
   logic [NUM_W-1:0]     num_q, num_d;
   logic [DEN_W-1:0]     den_q, den_d;
   logic [DEN_W-1:0]     rem_q, rem_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [SAMPLE_W-1:0]  avg_new, min_new, max_new;
   logic [DEN_W:0]       rem_shift;
   logic [DEN_W-1:0]     rem_sub;
   logic                 q_bit;

   always_ff @(posedge clki) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (cal_clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (sample_valid) state_d = S_ACCUM;
            S_ACCUM:  state_d = S_CAL;
            S_CAL:    state_d = (fill_q == FILL_FULL) ? S_DIVIDE : S_IDLE;
            S_DIVIDE: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Calibration uses the freshly computed average, so min/max and the divider
   // operands are all derived from the same value in the CAL cycle.
   always_comb begin
      avg_new   = SAMPLE_W'(sum_q >> AVG_LOG2);
      min_new   = (avg_new < min_q) ? avg_new : min_q;
      max_new   = (avg_new > max_q) ? avg_new : max_q;
      rem_shift = {rem_q, num_q[NUM_W-1]};
      q_bit     = (rem_shift >= {1'b0, den_q});
      rem_sub   = rem_shift[DEN_W-1:0] - den_q;
   end

   always_comb begin
      smp_d   = smp_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      fill_d  = fill_q;
      sum_d   = sum_q;
      avg_d   = avg_q;
      min_d   = min_q;
      max_d   = max_q;
      level_d = level_q;
      lv_d    = 1'b0;
      ovr_d   = ovr_q;
      num_d   = num_q;
      den_d   = den_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      if (cal_clear) begin
         for (int i = 0; i < WIN; i++) win_d[i] = '0;
         ptr_d  = '0;
         fill_d = '0;
         sum_d  = '0;
         min_d  = '1;
         max_d  = '0;
         ovr_d  = 1'b0;
      end else begin
         if (sample_valid && state_q != S_IDLE) ovr_d = 1'b1;
         case (state_q)
            S_IDLE: if (sample_valid) smp_d = sample;
            S_ACCUM: begin
               sum_d        = sum_q - SUM_W'(win_q[ptr_q]) + SUM_W'(smp_q);
               win_d[ptr_q] = smp_q;
               ptr_d        = ptr_q + 1'b1;
               if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
            end
            S_CAL: begin
               avg_d = avg_new;
               if (fill_q == FILL_FULL) begin
                  min_d = min_new;
                  max_d = max_new;
                  num_d = {avg_new - min_new, 4'b0000};
                  den_d = {1'b0, max_new} - {1'b0, min_new} + 1'b1;
                  rem_d = '0;
                  cnt_d = CNT_W'(NUM_W - 1);
               end
            end
            S_DIVIDE: begin
               num_d = {num_q[NUM_W-2:0], q_bit};
               rem_d = q_bit ? rem_sub : rem_shift[DEN_W-1:0];
               cnt_d = cnt_q - 1'b1;
            end
            S_DONE: begin
               level_d = num_q[3:0];
               lv_d    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clki) begin
      if (!resetn) begin
         smp_q <= '0;
         for (int i = 0; i < WIN; i++) win_q[i] <= '0;
         ptr_q   <= '0;
         fill_q  <= '0;
         sum_q   <= '0;
         avg_q   <= '0;
         min_q   <= '1;
         max_q   <= '0;
         level_q <= '0;
         lv_q    <= 1'b0;
         ovr_q   <= 1'b0;
         num_q   <= '0;
         den_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         smp_q   <= smp_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         fill_q  <= fill_d;
         sum_q   <= sum_d;
         avg_q   <= avg_d;
         min_q   <= min_d;
         max_q   <= max_d;
         level_q <= level_d;
         lv_q    <= lv_d;
         ovr_q   <= ovr_d;
         num_q   <= num_d;
         den_q   <= den_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level       = level_q;
   assign level_valid = lv_q;
   assign avg         = avg_q;
   assign cal_min     = min_q;
   assign cal_max     = max_q;
   assign busy        = (state_q != S_IDLE);
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_rcdp_level_scaler.sv
// Directed bench for rcdp_level_scaler: averaging, calibration, divide latency,
// overrun, cal_clear and reset aborts against hand-computed values.
module tb_rcdp_level_scaler;

   logic        clki;
   logic        resetn;
   logic        sample_valid;
   logic [31:0] sample;
   logic        cal_clear;
   logic [3:0]  level;
   logic        level_valid;
   logic [31:0] avg;
   logic [31:0] cal_min;
   logic [31:0] cal_max;
   logic        busy;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   rcdp_level_scaler #(.AVG_LOG2(2), .SAMPLE_W(32)) dut (
      .clki(clki), .resetn(resetn), .sample_valid(sample_valid), .sample(sample),
      .cal_clear(cal_clear), .level(level), .level_valid(level_valid), .avg(avg),
      .cal_min(cal_min), .cal_max(cal_max), .busy(busy), .overrun(overrun)
   );

   initial begin
      clki = 1'b0;
      forever #5 clki = ~clki;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
      end
   endtask

   // Iteration i observes the state just after the i-th edge following the reference edge.
   task automatic waitResult(input string tag, input int expLat, input bit expPulse,
                             input logic [3:0] expLevel, input logic [31:0] expAvg,
                             input logic [31:0] expMin, input logic [31:0] expMax);
      int pulseAt = 0;
      bit done = 0;
      for (int i = 1; i <= 60 && !done; i++) begin
         @(negedge clki);
         if (level_valid && pulseAt == 0) pulseAt = i;
         if (!busy) done = 1;
      end
      checkOutput({tag, "_idle"}, busy, 0);
      if (expPulse) begin
         checkOutput({tag, "_latency"}, pulseAt, expLat);
         checkOutput({tag, "_level"}, level, expLevel);
      end else begin
         checkOutput({tag, "_nopulse"}, pulseAt, 0);
      end
      checkOutput({tag, "_avg"}, avg, expAvg);
      checkOutput({tag, "_min"}, cal_min, expMin);
      checkOutput({tag, "_max"}, cal_max, expMax);
      if (expPulse) begin
         @(negedge clki);
         checkOutput({tag, "_pulsewidth"}, level_valid, 0);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [31:0] val, input bit expPulse,
                                input logic [3:0] expLevel, input logic [31:0] expAvg,
                                input logic [31:0] expMin, input logic [31:0] expMax);
      @(negedge clki);
      sample_valid = 1'b1;
      sample       = val;
      @(negedge clki);
      sample_valid = 1'b0;
      waitResult(tag, 39, expPulse, expLevel, expAvg, expMin, expMax);
   endtask

   task automatic checkNoPulse(input string tag, input int cycles);
      int pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clki);
         if (level_valid) pulses++;
      end
      checkOutput(tag, pulses, 0);
   endtask

   initial begin
      resetn       = 1'b0;
      sample_valid = 1'b0;
      sample       = '0;
      cal_clear    = 1'b0;
      repeat (3) @(negedge clki);
      checkOutput("rst_level", level, 0);
      checkOutput("rst_lv", level_valid, 0);
      checkOutput("rst_avg", avg, 0);
      checkOutput("rst_min", cal_min, ONES);
      checkOutput("rst_max", cal_max, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_ovr", overrun, 0);
      resetn = 1'b1;

      // Filling the window: only the fourth sample triggers a divide.
      applyStimulus("a100_1", 100, 0, 0, 25, ONES, 0);
      applyStimulus("a100_2", 100, 0, 0, 50, ONES, 0);
      applyStimulus("a100_3", 100, 0, 0, 75, ONES, 0);
      applyStimulus("a100_4", 100, 1, 0, 100, 100, 100);

      applyStimulus("b200_1", 200, 1, 15, 125, 100, 125);
      applyStimulus("b200_2", 200, 1, 15, 150, 100, 150);
      applyStimulus("b200_3", 200, 1, 15, 175, 100, 175);
      applyStimulus("b200_4", 200, 1, 15, 200, 100, 200);

      applyStimulus("c150_1", 150, 1, 13, 187, 100, 200);
      applyStimulus("c150_2", 150, 1, 11, 175, 100, 200);
      applyStimulus("c150_3", 150, 1, 9, 162, 100, 200);
      applyStimulus("c150_4", 150, 1, 7, 150, 100, 200);

      // Sample strobed 10 cycles after acceptance is dropped and flags overrun.
      @(negedge clki);
      sample_valid = 1'b1;
      sample       = 150;
      @(negedge clki);
      sample_valid = 1'b0;
      repeat (9) @(negedge clki);
      sample_valid = 1'b1;
      sample       = 0;
      @(negedge clki);
      sample_valid = 1'b0;
      checkOutput("ovr_set", overrun, 1);
      waitResult("ovr", 29, 1, 7, 150, 100, 200);
      checkOutput("ovr_sticky", overrun, 1);
      @(negedge clki);
      cal_clear = 1'b1;
      @(negedge clki);
      cal_clear = 1'b0;
      checkOutput("clr_ovr", overrun, 0);
      checkOutput("clr_min", cal_min, ONES);
      checkOutput("clr_max", cal_max, 0);
      checkOutput("clr_level", level, 7);

      // cal_clear in the middle of a divide aborts without a pulse.
      applyStimulus("d100_1", 100, 0, 0, 25, ONES, 0);
      applyStimulus("d100_2", 100, 0, 0, 50, ONES, 0);
      applyStimulus("d100_3", 100, 0, 0, 75, ONES, 0);
      @(negedge clki);
      sample_valid = 1'b1;
      sample       = 100;
      @(negedge clki);
      sample_valid = 1'b0;
      repeat (9) @(negedge clki);
      checkOutput("div_busy", busy, 1);
      cal_clear = 1'b1;
      @(negedge clki);
      cal_clear = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_lv", level_valid, 0);
      checkOutput("abort_min", cal_min, ONES);
      checkOutput("abort_max", cal_max, 0);
      checkOutput("abort_level", level, 7);
      checkNoPulse("abort_quiet", 40);
      applyStimulus("e300_1", 300, 0, 0, 75, ONES, 0);
      applyStimulus("e300_2", 300, 0, 0, 150, ONES, 0);
      applyStimulus("e300_3", 300, 0, 0, 225, ONES, 0);

      // One-cycle reset while dividing.
      @(negedge clki);
      sample_valid = 1'b1;
      sample       = 300;
      @(negedge clki);
      sample_valid = 1'b0;
      repeat (9) @(negedge clki);
      checkOutput("div2_busy", busy, 1);
      resetn = 1'b0;
      @(negedge clki);
      resetn = 1'b1;
      checkOutput("mrst_level", level, 0);
      checkOutput("mrst_lv", level_valid, 0);
      checkOutput("mrst_avg", avg, 0);
      checkOutput("mrst_min", cal_min, ONES);
      checkOutput("mrst_max", cal_max, 0);
      checkOutput("mrst_busy", busy, 0);
      checkOutput("mrst_ovr", overrun, 0);
      checkNoPulse("mrst_quiet", 40);
      applyStimulus("f40_1", 40, 0, 0, 10, ONES, 0);
      applyStimulus("f40_2", 40, 0, 0, 20, ONES, 0);
      applyStimulus("f40_3", 40, 0, 0, 30, ONES, 0);
      applyStimulus("f40_4", 40, 1, 0, 40, 40, 40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
